id_ex_hazard_stage: RTL and testbench

//  ID->EX boundary: registers control_unit outputs plus decode fields into the ID/EX pipeline register.

---
 rtl/id_ex_hazard_pkg.sv | 27 ++
 rtl/id_ex_hazard_stage_sat_counter.sv | 16 +
 rtl/id_ex_hazard_stage.sv | 131 +++++++++++++
 tb/tb_id_ex_hazard_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_hazard_pkg.sv
// Shared encodings for the ID/EX hazard stage: FSM states, ALUOp values, control bundle.
package id_ex_hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_FROZEN = 2'd2
  } state_e;

  // Same ALUOp encoding that control_unit drives
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_R_TYPE = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_2_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/id_ex_hazard_stage_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge arst) begin
    if (arst)                  cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID->EX pipeline register with load-use hazard detection, EX flush, memory freeze
// and saturating stall/bubble counters.
module id_ex_hazard_stage
  import id_ex_hazard_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             mem_stall,
  input  logic             ex_flush,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic [1:0]       id_alu_op,
  input  logic             id_reg_dst,
  input  logic             id_branch,
  input  logic             id_mem_read,
  input  logic             id_mem_2_reg,
  input  logic             id_mem_write,
  input  logic             id_alu_src,
  input  logic             id_reg_write,
  input  logic             id_jump,
  output logic [1:0]       ex_alu_op,
  output logic             ex_reg_dst,
  output logic             ex_branch,
  output logic             ex_mem_read,
  output logic             ex_mem_2_reg,
  output logic             ex_mem_write,
  output logic             ex_alu_src,
  output logic             ex_reg_write,
  output logic             ex_jump,
  output logic [REG_W-1:0] ex_rs1,
  output logic [REG_W-1:0] ex_rs2,
  output logic [REG_W-1:0] ex_rd,
  output logic             ex_valid,
  output logic             pc_write,
  output logic             if_id_write,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [1:0]       state
);

  ctrl_t      id_ctrl, ex_ctrl;
  state_e     state_q, state_d;
  logic       uses_rs2, hazard, hold, bubble, hz_bubble;

  assign id_ctrl = '{reg_dst: id_reg_dst, branch: id_branch, mem_read: id_mem_read,
                     mem_2_reg: id_mem_2_reg, mem_write: id_mem_write, alu_src: id_alu_src,
                     reg_write: id_reg_write, jump: id_jump, alu_op: id_alu_op};

  assign uses_rs2 = ~id_alu_src | id_mem_write;
  assign hazard   = id_valid & ex_valid & ex_ctrl.mem_read & ex_ctrl.reg_write & (ex_rd != '0)
                  & ((ex_rd == id_rs1) | (uses_rs2 & (ex_rd == id_rs2)));

  // Priority: mem_stall > ex_flush > hazard > normal
  always_comb begin
    state_d   = ST_RUN;
    pc_write  = 1'b1;
    hold      = 1'b0;
    bubble    = 1'b0;
    hz_bubble = 1'b0;
    if (mem_stall) begin
      hold     = 1'b1;
      pc_write = 1'b0;
      state_d  = ST_FROZEN;
    end else if (ex_flush) begin
      bubble   = 1'b1;
    end else if (hazard) begin
      bubble    = 1'b1;
      hz_bubble = 1'b1;
      pc_write  = 1'b0;
      state_d   = ST_BUBBLE;
    end
  end

  assign if_id_write = pc_write;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  assign state = state_q;

  // Bubbles also zero the indices so the next cycle cannot re-trigger the hazard
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ex_ctrl  <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
      ex_valid <= 1'b0;
    end else if (!hold) begin
      if (bubble) begin
        ex_ctrl  <= '0;
        ex_rs1   <= '0;
        ex_rs2   <= '0;
        ex_rd    <= '0;
        ex_valid <= 1'b0;
      end else begin
        ex_ctrl  <= id_valid ? id_ctrl : '0;
        ex_rs1   <= id_rs1;
        ex_rs2   <= id_rs2;
        ex_rd    <= id_rd;
        ex_valid <= id_valid;
      end
    end
  end

  assign ex_alu_op    = ex_ctrl.alu_op;
  assign ex_reg_dst   = ex_ctrl.reg_dst;
  assign ex_branch    = ex_ctrl.branch;
  assign ex_mem_read  = ex_ctrl.mem_read;
  assign ex_mem_2_reg = ex_ctrl.mem_2_reg;
  assign ex_mem_write = ex_ctrl.mem_write;
  assign ex_alu_src   = ex_ctrl.alu_src;
  assign ex_reg_write = ex_ctrl.reg_write;
  assign ex_jump      = ex_ctrl.jump;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .arst(arst), .inc(~pc_write), .cnt(stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk(clk), .arst(arst), .inc(hz_bubble), .cnt(bubble_cnt)
  );

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage; counters built 2 bits wide so saturation is reachable.
module tb_id_ex_hazard_stage;
  import id_ex_hazard_pkg::*;

  localparam int CNT_W = 2;
  localparam int REG_W = 5;

  logic             clk = 1'b0;
  logic             arst, mem_stall, ex_flush, id_valid;
  logic [REG_W-1:0] id_rs1, id_rs2, id_rd;
  logic [1:0]       id_alu_op;
  logic             id_reg_dst, id_branch, id_mem_read, id_mem_2_reg;
  logic             id_mem_write, id_alu_src, id_reg_write, id_jump;
  logic [1:0]       ex_alu_op;
  logic             ex_reg_dst, ex_branch, ex_mem_read, ex_mem_2_reg;
  logic             ex_mem_write, ex_alu_src, ex_reg_write, ex_jump;
  logic [REG_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic             ex_valid, pc_write, if_id_write;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;
  logic [1:0]       state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_hazard_stage #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .clk(clk), .arst(arst), .mem_stall(mem_stall), .ex_flush(ex_flush),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_alu_op(id_alu_op), .id_reg_dst(id_reg_dst), .id_branch(id_branch),
    .id_mem_read(id_mem_read), .id_mem_2_reg(id_mem_2_reg), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_jump(id_jump),
    .ex_alu_op(ex_alu_op), .ex_reg_dst(ex_reg_dst), .ex_branch(ex_branch),
    .ex_mem_read(ex_mem_read), .ex_mem_2_reg(ex_mem_2_reg), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_jump(ex_jump),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .state(state)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one ID instruction; ctrl bits {reg_dst,branch,mem_read,mem_2_reg,mem_write,alu_src,reg_write,jump}
  task automatic drive(input logic v, input int rs1, input int rs2, input int rd,
                       input logic [1:0] aop, input logic [7:0] c);
    id_valid  = v;
    id_rs1    = REG_W'(rs1);
    id_rs2    = REG_W'(rs2);
    id_rd     = REG_W'(rd);
    id_alu_op = aop;
    {id_reg_dst, id_branch, id_mem_read, id_mem_2_reg,
     id_mem_write, id_alu_src, id_reg_write, id_jump} = c;
    #1;
  endtask

  task automatic lw(input int rd, input int rs1);  drive(1, rs1, 0, rd, ALU_ADD, 8'b0011_0110); endtask
  task automatic add(input int rd, input int rs1, input int rs2); drive(1, rs1, rs2, rd, ALU_R_TYPE, 8'b1000_0010); endtask
  task automatic sw(input int rs1, input int rs2); drive(1, rs1, rs2, 0, ALU_ADD, 8'b0000_1100); endtask
  task automatic addi(input int rd, input int rs1, input int rs2f); drive(1, rs1, rs2f, rd, ALU_ADD, 8'b0000_0110); endtask
  task automatic nop(); drive(0, 0, 0, 0, ALU_ADD, 8'b0); endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mem_stall = 1'b0;
    ex_flush  = 1'b0;
    nop();
    arst = 1'b1;
    #3;
    arst = 1'b0;
    step();
  endtask

  initial begin
    arst = 1'b0;
    do_reset();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_state", state, 0);
    chk("rst_pc_write", pc_write, 1);

    // T1: async reset mid-run
    lw(5, 2);
    step();
    chk("t1_pre_mem_read", ex_mem_read, 1);
    chk("t1_pre_rd", ex_rd, 5);
    add(6, 5, 1);
    #2;
    arst = 1'b1;
    #1;
    chk("t1_ex_valid", ex_valid, 0);
    chk("t1_ctrl", {ex_reg_dst, ex_mem_read, ex_mem_2_reg, ex_alu_src, ex_reg_write}, 0);
    chk("t1_rd", ex_rd, 0);
    chk("t1_state", state, 0);
    chk("t1_cnts", {stall_cnt, bubble_cnt}, 0);
    chk("t1_pc_write", pc_write, 1);
    arst = 1'b0;

    // T2: load-use
    do_reset();
    lw(5, 2);
    step();
    add(6, 5, 1);
    chk("t2_pc_write", pc_write, 0);
    chk("t2_if_id_write", if_id_write, 0);
    step();
    chk("t2_bubble_valid", ex_valid, 0);
    chk("t2_bubble_rw", ex_reg_write, 0);
    chk("t2_bubble_cnt", bubble_cnt, 1);
    chk("t2_stall_cnt", stall_cnt, 1);
    chk("t2_state_bubble", state, 1);
    chk("t2_pc_write_after", pc_write, 1);
    step();
    chk("t2_add_rd", ex_rd, 6);
    chk("t2_add_valid", ex_valid, 1);
    chk("t2_add_aop", ex_alu_op, ALU_R_TYPE);
    chk("t2_state_run", state, 0);
    chk("t2_bubble_cnt_hold", bubble_cnt, 1);

    // T3: rs2 use, x0, alu_src
    do_reset();
    lw(5, 2);
    step();
    sw(1, 5);
    chk("t3_sw_stall", pc_write, 0);
    step();
    chk("t3_sw_bubble_cnt", bubble_cnt, 1);
    lw(0, 2);
    step();
    add(7, 0, 0);
    chk("t3_x0_no_stall", pc_write, 1);
    step();
    chk("t3_x0_rd", ex_rd, 7);
    lw(5, 2);
    step();
    addi(8, 1, 5);
    chk("t3_addi_no_stall", pc_write, 1);
    step();
    chk("t3_addi_rd", ex_rd, 8);
    chk("t3_bubble_cnt", bubble_cnt, 1);

    // T4: flush beats hazard
    do_reset();
    lw(5, 2);
    step();
    add(6, 5, 1);
    ex_flush = 1'b1;
    #1;
    chk("t4_pc_write", pc_write, 1);
    step();
    ex_flush = 1'b0;
    chk("t4_valid", ex_valid, 0);
    chk("t4_mem_read", ex_mem_read, 0);
    chk("t4_bubble_cnt", bubble_cnt, 0);
    chk("t4_state", state, 0);

    // T5: freeze 3 cycles then release
    do_reset();
    lw(5, 2);
    step();
    add(6, 1, 2);
    mem_stall = 1'b1;
    #1;
    chk("t5_pc_write", pc_write, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_state", state, 2);
      chk("t5_hold_rd", ex_rd, 5);
      chk("t5_hold_mem_read", ex_mem_read, 1);
    end
    chk("t5_stall_cnt", stall_cnt, 3);
    mem_stall = 1'b0;
    #1;
    chk("t5_release_pc", pc_write, 1);
    step();
    chk("t5_load_rd", ex_rd, 6);
    chk("t5_load_mem_read", ex_mem_read, 0);
    chk("t5_state_run", state, 0);

    // T6: bubble counter saturation
    do_reset();
    for (int i = 0; i < 5; i++) begin
      lw(5, 2);
      step();
      add(6, 5, 1);
      step();
    end
    chk("t6_bubble_sat", bubble_cnt, 3);
    chk("t6_stall_sat", stall_cnt, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
